op_sel_stage: RTL and testbench
===============================

OP_SEL_STAGE -- requirements
Module: op_sel_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter NSRC, default 3, number of operand sources (1..15).
REQ-003 Parameter SELW, default 2, selector width; SHALL satisfy 2**SELW >= NSRC+1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream request carries a valid selector and sources.
REQ-007 in_ready  output  1  stage can accept a request this cycle.
REQ-008 sel  input  SELW  source selector.
REQ-009 src  input  NSRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-010 flush  input  1  discard all buffered operands.
REQ-011 out_valid  output  1  out_data holds a selected operand.
REQ-012 out_ready  input  1  downstream consumes the operand this cycle.
REQ-013 out_data  output  WIDTH  selected operand.
REQ-014 out_sel_err  output  1  the presented operand came from an out-of-range selector.

Function
REQ-015 Selection SHALL be: sel==0 -> all-zero; sel==k, 1<=k<=NSRC -> source k-1; sel>NSRC -> source 0 (default line) with error flag 1.
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-017 Selection SHALL be evaluated combinationally at accept time; the result SHALL be captured with its error flag, and later src/sel changes SHALL NOT affect a captured entry.
REQ-018 Storage SHALL be two entries: main (drives outputs) and skid.
REQ-019 Latency SHALL be exactly 1 cycle: an operand accepted in cycle N with the stage empty SHALL appear with out_valid=1 in cycle N+1.
REQ-020 Throughput SHALL be one operand per cycle while out_ready=1.
REQ-021 in_ready SHALL be a registered signal equal to !skid_valid; it SHALL NOT depend combinationally on out_ready or in_valid.
REQ-022 If accepting while main is full and not draining, the operand SHALL go to skid; in_ready SHALL drop in the next cycle.
REQ-023 When main drains and skid is full, skid SHALL move to main in the same edge; a simultaneous accept is impossible (in_ready=0).
REQ-024 When main drains, skid is empty and an accept occurs, the new operand SHALL load main directly.
REQ-025 While out_valid && !out_ready, out_data and out_sel_err SHALL hold stable.
REQ-026 Ordering SHALL be strict FIFO; no operand SHALL be duplicated or dropped except by flush or reset.
REQ-027 flush SHALL clear both entries at the next edge: out_valid=0 and in_ready=1 in the following cycle.
REQ-028 An accept in a flush cycle SHALL be discarded; flush SHALL take priority over concurrent accept and drain.
REQ-029 out_sel_err SHALL be 0 whenever out_valid=0.

Reset
REQ-030 With rst=1 at an edge, the following cycle SHALL have out_valid=0, out_data=0, out_sel_err=0 and in_ready=1, and both entries SHALL be empty.
REQ-031 rst SHALL override flush and all handshakes; in-flight operands SHALL be discarded.
REQ-032 Inputs during reset SHALL be ignored; no operand accepted in a reset cycle SHALL appear afterward.

Verification
REQ-033 Defaults; src0=0x11, src1=0x22, src2=0x33; one accept each of sel=0,1,2,3 with out_ready=1 -> out_data 0x0, 0x11, 0x22, 0x33 on consecutive cycles one cycle after each accept; out_sel_err=0 throughout.
REQ-034 sel=3 with NSRC=2 (SELW=2), src0=0xAA -> out_data=0xAA and out_sel_err=1 for that operand only.
REQ-035 out_ready=0; accept A=0x1 then B=0x2 -> in_ready=0 from the cycle after B; out_data holds 0x1; raise out_ready -> 0x1 then 0x2 out, in_ready=1 again one cycle after the skid empties.
REQ-036 Sources change to 0xFF after accept while stalled 3 cycles -> the captured value is still presented unchanged.
REQ-037 Both entries full, then flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed operands and the same-cycle input never appear.
REQ-038 Both entries full, then rst=1 for one cycle -> next cycle out_valid=0, out_data=0, in_ready=1; streaming 100 random operands afterwards with random out_ready matches a reference FIFO model.

Source files
------------

// File: rtl/op_sel_stage_if.sv
// Handshake bundle for op_sel_stage: operand request side, flush, and selected-operand output side.
interface op_sel_stage_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SELW  = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SELW-1:0]       sel;
  logic [NSRC*WIDTH-1:0] src;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_sel_err;

  modport master (
    output in_valid, sel, src, flush, out_ready,
    input  in_ready, out_valid, out_data, out_sel_err
  );

  modport slave (
    input  in_valid, sel, src, flush, out_ready,
    output in_ready, out_valid, out_data, out_sel_err
  );
endinterface

// File: rtl/op_sel_stage.sv
// Operand select stage: picks one of NSRC sources (or zero) at accept time and buffers it
// in a main+skid pair so in_ready is a pure register output.
module op_sel_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SELW  = 2
) (
  input logic            clk,
  input logic            rst,
  op_sel_stage_if.slave  bus
);

  logic [WIDTH-1:0] src_arr [NSRC];
  logic [WIDTH-1:0] pick_data;
  logic             pick_err;

  logic             main_valid_reg, main_valid_next;
  logic [WIDTH-1:0] main_data_reg,  main_data_next;
  logic             main_err_reg,   main_err_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [WIDTH-1:0] skid_data_reg,  skid_data_next;
  logic             skid_err_reg,   skid_err_next;

  logic accept;
  logic drain;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_arr[gi] = bus.src[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // sel==0 yields zero; anything above NSRC falls back to source 0 and raises the error flag
  always_comb begin
    pick_data = '0;
    pick_err  = 1'b0;
    if (int'(bus.sel) > NSRC) begin
      pick_data = src_arr[0];
      pick_err  = 1'b1;
    end else begin
      for (int k = 1; k <= NSRC; k++) begin
        if (bus.sel == SELW'(k)) pick_data = src_arr[k-1];
      end
    end
  end

  assign accept = bus.in_valid && !skid_valid_reg;
  assign drain  = main_valid_reg && bus.out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    main_err_next   = main_err_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_err_next   = skid_err_reg;
    if (bus.flush) begin
      main_valid_next = 1'b0;
      main_data_next  = '0;
      main_err_next   = 1'b0;
      skid_valid_next = 1'b0;
      skid_data_next  = '0;
      skid_err_next   = 1'b0;
    end else if (drain || !main_valid_reg) begin
      // main is free this edge: skid has priority; accept cannot coincide with a full skid
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        main_err_next   = skid_err_reg;
        skid_valid_next = 1'b0;
        skid_err_next   = 1'b0;
      end else if (accept) begin
        main_valid_next = 1'b1;
        main_data_next  = pick_data;
        main_err_next   = pick_err;
      end else begin
        main_valid_next = 1'b0;
        main_err_next   = 1'b0;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = pick_data;
      skid_err_next   = pick_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      main_err_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_err_reg   <= 1'b0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      main_err_reg   <= main_err_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_err_reg   <= skid_err_next;
    end
  end

  assign bus.in_ready    = !skid_valid_reg;
  assign bus.out_valid   = main_valid_reg;
  assign bus.out_data    = main_data_reg;
  assign bus.out_sel_err = main_valid_reg && main_err_reg;

endmodule

// File: tb/tb_op_sel_stage.sv
// Self-checking bench for op_sel_stage: directed scenarios plus a random stream against a queue model.
module tb_op_sel_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  op_sel_stage_if #(.WIDTH(32), .NSRC(3), .SELW(2)) bus ();
  op_sel_stage_if #(.WIDTH(32), .NSRC(2), .SELW(2)) bus2 ();

  op_sel_stage #(.WIDTH(32), .NSRC(3), .SELW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  op_sel_stage #(.WIDTH(32), .NSRC(2), .SELW(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  always #5 clk = ~clk;

  // model: FIFO of {err, data} entries, at most two deep; in_ready means fewer than two held
  logic [32:0] mq [$];

  function automatic logic [32:0] ref_pick(input int s, input logic [95:0] sr, input int nsrc);
    logic [95:0] sh;
    if (s == 0) return 33'd0;
    if (s > nsrc) return {1'b1, sr[31:0]};
    sh = sr >> ((s - 1) * 32);
    return {1'b0, sh[31:0]};
  endfunction

  task automatic drive(input logic iv, input logic [1:0] s, input logic [95:0] sr,
                       input logic ordy, input logic fl, input logic rs);
    bit acc;
    bit drn;
    bus.in_valid  = iv;
    bus.sel       = s;
    bus.src       = sr;
    bus.out_ready = ordy;
    bus.flush     = fl;
    rst           = rs;
    acc = iv && (mq.size() < 2);
    drn = ordy && (mq.size() > 0);
    if (rs || fl) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(ref_pick(int'(s), sr, 3));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 2'd1, 96'h1234, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'd2, 96'h5678, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'd0, 96'h0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({bus.out_valid, bus.out_sel_err, bus.in_ready} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: valid/err/ready got %b%b%b want 001", bus.out_valid, bus.out_sel_err, bus.in_ready);
    end
    n_tests++;
    if (bus.out_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h want 0", bus.out_data);
    end
  endtask

  task automatic test_select();
    logic [31:0] exp_tab [4];
    logic [95:0] sr;
    exp_tab[0] = 32'h0;  exp_tab[1] = 32'h11;
    exp_tab[2] = 32'h22; exp_tab[3] = 32'h33;
    sr = {32'h33, 32'h22, 32'h11};
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), sr, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (!bus.out_valid || bus.out_data !== exp_tab[s] || bus.out_sel_err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL select_%0d: valid=%b data=%h err=%b want 1 %h 0", s, bus.out_valid, bus.out_data, bus.out_sel_err, exp_tab[s]);
      end
      $display("[TB] select sel=%0d out=%h", s, bus.out_data);
    end
    drive(1'b0, 2'd0, sr, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_sel_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL select_idle: valid=%b err=%b want 0 0", bus.out_valid, bus.out_sel_err);
    end
  endtask

  task automatic test_sel_err();
    logic [1:0]  sels [3];
    logic [32:0] exps [3];
    sels[0] = 2'd3; exps[0] = {1'b1, 32'hAA};
    sels[1] = 2'd1; exps[1] = {1'b0, 32'hAA};
    sels[2] = 2'd2; exps[2] = {1'b0, 32'h55};
    bus2.src = {32'h55, 32'hAA};
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus2.in_valid = 1'b1;
      bus2.sel = sels[i];
      @(negedge clk);
      n_tests++;
      if (!bus2.out_valid || {bus2.out_sel_err, bus2.out_data} !== exps[i]) begin
        n_fail++;
        $display("[TB] FAIL sel_err_%0d: valid=%b err=%b data=%h want err=%b data=%h", i, bus2.out_valid, bus2.out_sel_err, bus2.out_data, exps[i][32], exps[i][31:0]);
      end
      $display("[TB] nsrc2 sel=%0d out=%h err=%b", sels[i], bus2.out_data, bus2.out_sel_err);
    end
    bus2.in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus2.out_valid !== 1'b0 || bus2.out_sel_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sel_err_idle: valid=%b err=%b want 0 0", bus2.out_valid, bus2.out_sel_err);
    end
  endtask

  task automatic test_skid();
    drive(1'b1, 2'd1, 96'h1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (!bus.out_valid || bus.out_data !== 32'h1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL skid_a: valid=%b data=%h ready=%b want 1 1 1", bus.out_valid, bus.out_data, bus.in_ready);
    end
    drive(1'b1, 2'd1, 96'h2, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h1) begin
      n_fail++;
      $display("[TB] FAIL skid_b: ready=%b data=%h want 0 1", bus.in_ready, bus.out_data);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd1, {3{32'hFF}}, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (!bus.out_valid || bus.out_data !== 32'h1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL skid_hold_%0d: valid=%b data=%h ready=%b want 1 1 0", i, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    drive(1'b0, 2'd1, {3{32'hFF}}, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (!bus.out_valid || bus.out_data !== 32'h2 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL skid_drain_b: valid=%b data=%h ready=%b want 1 2 1", bus.out_valid, bus.out_data, bus.in_ready);
    end
    drive(1'b0, 2'd1, {3{32'hFF}}, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL skid_empty: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 2'd1, 96'h7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 96'h8, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 96'h9, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sel_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_full: valid=%b ready=%b err=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.out_sel_err);
    end
    // main occupied and in_ready high: the same-cycle accept must still be dropped
    drive(1'b1, 2'd1, 96'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 96'hB, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 96'h0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_accept: valid=%b data=%h want valid 0", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_reset_full();
    drive(1'b1, 2'd2, 96'h500, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 96'h600, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 96'h700, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_full: valid=%b data=%h ready=%b want 0 0 1", bus.out_valid, bus.out_data, bus.in_ready);
    end
  endtask

  task automatic test_stream();
    int          accepted = 0;
    int          cyc = 0;
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [1:0]  s;
    logic [95:0] sr;
    while ((accepted < 100 || mq.size() != 0) && cyc < 3000) begin
      iv   = (accepted < 100) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      fl   = ($urandom_range(63) == 0);
      s    = 2'($urandom_range(3));
      sr   = {$urandom, $urandom, $urandom};
      if (iv && mq.size() < 2) accepted++;
      drive(iv, s, sr, ordy, fl, 1'b0);
      cyc++;
      n_tests++;
      if (bus.out_valid !== (mq.size() != 0) || bus.in_ready !== (mq.size() < 2)) begin
        n_fail++;
        $display("[TB] FAIL stream_ctrl cyc %0d: valid=%b ready=%b want %b %b", cyc, bus.out_valid, bus.in_ready, mq.size() != 0, mq.size() < 2);
      end
      n_tests++;
      if (mq.size() != 0) begin
        if ({bus.out_sel_err, bus.out_data} !== mq[0]) begin
          n_fail++;
          $display("[TB] FAIL stream_data cyc %0d: err=%b data=%h want err=%b data=%h", cyc, bus.out_sel_err, bus.out_data, mq[0][32], mq[0][31:0]);
        end
        if (ordy) $display("[TB] stream out data=%h err=%b", bus.out_data, bus.out_sel_err);
      end else if (bus.out_sel_err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stream_err_idle cyc %0d: err=%b want 0", cyc, bus.out_sel_err);
      end
    end
    n_tests++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("[TB] FAIL stream_timeout: accepted=%0d held=%0d after %0d cycles", accepted, mq.size(), cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.sel = '0; bus.src = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.sel = '0; bus2.src = '0; bus2.flush = 1'b0; bus2.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_select();
    test_sel_err();
    test_skid();
    test_flush();
    test_reset_full();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
